vfpu_engine: RTL and testbench
==============================

Name: vfpu_engine

Overview:
- Pipelined lane-wise SIMD integer ALU. Consumes the two fenced operand streams and produces the result stream for the stream sink; replaces the inline adder currently glued inside the streamer.
- Sits between the streamer's fence outputs and its sink input.
- Processes a job of `len_i` beats launched by the controller FSM, then pulses `done_o`.

Parameters:
- `DATA_WIDTH`, 32, stream data width in bits; must be a multiple of 32.
- `LANE_WIDTH`, 32, SIMD lane width; number of lanes `NB_LANES` = `DATA_WIDTH/LANE_WIDTH`.
- `PIPE_STAGES`, 2, register stages between operand handshake and result output; legal range 1..4.
- `LEN_WIDTH`, 16, width of the job beat counter.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `clear_i`  in  1  synchronous flush, same effect as `rst_i`
- `start_i`  in  1  job launch pulse
- `opcode_i`  in  3  operation (`vfpu_op_t`), sampled on accepted start
- `len_i`  in  `LEN_WIDTH`  beats in job, sampled on accepted start
- `busy_o`  out  1  job in progress
- `done_o`  out  1  one-cycle pulse at job end
- `a_valid_i`, `b_valid_i`  in  1  operand valid
- `a_ready_o`, `b_ready_o`  out  1  operand ready
- `a_data_i`, `b_data_i`  in  `DATA_WIDTH`  operand data
- `a_strb_i`, `b_strb_i`  in  `DATA_WIDTH/8`  operand byte strobes
- `res_valid_o`  out  1  result valid
- `res_ready_i`  in  1  result ready
- `res_data_o`  out  `DATA_WIDTH`  result data
- `res_strb_o`  out  `DATA_WIDTH/8`  result strobes

Behaviour:
- Reset/clear: FSM goes to IDLE; all stage valids 0; counters 0.
  - Outputs after reset: `busy_o`=0, `done_o`=0, `a_ready_o`=`b_ready_o`=0, `res_valid_o`=0, `res_data_o`=0, `res_strb_o`=0.
  - A mid-job reset or clear discards in-flight beats without pulsing `done_o`.
- FSM states:
  - IDLE: `start_i`=1 latches `opcode_i`, `len_i`, `in_cnt`=`len_i`, `out_cnt`=`len_i`. Goes to RUN, or to DONE if `len_i`=0.
  - RUN: accepts operands while `in_cnt`>0. When the last result handshake occurs (`out_cnt` 1->0), goes to DONE.
  - DONE: `done_o`=1 for exactly one cycle, then IDLE.
- `start_i` is ignored outside IDLE. `busy_o`=1 in RUN and DONE.
- Accept condition: `acc` = RUN & `in_cnt`>0 & `a_valid_i` & `b_valid_i` & stage0_can_load.
  - `a_ready_o` = `b_ready_o` = `acc`.
  - Both operands are always consumed in the same cycle; an operand is never consumed alone.
- Pipeline stage k loads when it is empty or stage k+1 advances this cycle. The last stage advances on `res_ready_i`.
  - Full throughput of 1 beat/cycle under no backpressure.
  - Latency is exactly `PIPE_STAGES` cycles from `acc` to `res_valid_o`.
- Backpressure: with `res_ready_i`=0, the pipeline fills and then `acc`=0. Held data is stable and no beat is dropped or duplicated.
- `res_valid_o` must not depend combinationally on `res_ready_i`.
- Lane op, computed in stage 0, per lane, result truncated to `LANE_WIDTH` (wrap-around):
  - 0 ADD, 1 SUB (a-b), 2 MUL (low half).
  - 3 MIN, 4 MAX (signed).
  - 5 AND, 6 OR, 7 XOR.
- `res_strb_o` = `a_strb & b_strb` of the same beat. Data is computed regardless of strobe.
- Counters: `in_cnt` decrements on `acc`; `out_cnt` decrements on result handshake. `done_o` is only raised after `out_cnt` reaches 0.

Optional Feature:
- Macro `VFPU_ENGINE_SATURATE_EN`.
- Defined: ADD and SUB are signed-saturating per lane, clamping to +2^(LW-1)-1 / -2^(LW-1). A sticky `sat_o` output (1 bit, reset 0, cleared on accepted start) is set when any lane clamps.
- Undefined: ADD and SUB wrap, and the `sat_o` port does not exist.

Decomposition:
- Package `vfpu_package`:
  - `vfpu_op_t` enum (3 bits, values above).
  - `VFPU_LANE_WIDTH` constant.
  - `vfpu_state_t` (IDLE/RUN/DONE).
- Sub-module `vfpu_lane_alu`: one combinational lane, taking opcode, a, b and producing result (plus saturation flag when enabled), instantiated `NB_LANES` times in a generate loop. The engine keeps the FSM, counters and pipeline.

Test Plan:
- ADD, `len_i`=4, a={1,2,3,0xFFFFFFFF}, b={10,20,30,1}, `res_ready_i`=1 -> results {11,22,33,0}. First `res_valid_o` arrives 2 cycles after the first `acc`; `done_o` pulses once after the 4th handshake.
- SUB/MIN/MAX/MUL, `DATA_WIDTH`=64, a=0x00000005_FFFFFFFE, b=0x00000007_00000003 -> SUB 0xFFFFFFFE_FFFFFFFB, MIN 0x00000005_FFFFFFFE, MAX 0x00000007_00000003, MUL 0x00000023_FFFFFFFA.
- Backpressure: `len_i`=8 with `res_ready_i` toggling every cycle and `b_valid_i` deasserting randomly -> exactly 8 results, in order, stable while stalled, and `a_ready_o`=`b_ready_o` every cycle.
- `len_i`=0 start -> no operand ready; `done_o` pulses 1 cycle after start. A second start while busy is ignored.
- Mid-job `clear_i` after 3 of 6 beats -> outputs return to reset values next cycle and no `done_o`. A new ADD job `len_i`=1 (5+6) then yields 11.
- With `VFPU_ENGINE_SATURATE_EN`: ADD 0x7FFFFFFF+1 -> 0x7FFFFFFF with `sat_o`=1. SUB 0x80000000-1 -> 0x80000000. `sat_o` clears on the next start.

Source files
------------

// File: rtl/vfpu_package.sv
// Shared types for the SIMD integer ALU engine.
//   vfpu_op_t       : 3-bit lane operation code
//   vfpu_state_t    : job controller state
//   VFPU_LANE_WIDTH : default lane width
package vfpu_package;

  localparam int VFPU_LANE_WIDTH = 32;

  typedef enum logic [2:0] {
    VFPU_ADD = 3'd0,
    VFPU_SUB = 3'd1,
    VFPU_MUL = 3'd2,
    VFPU_MIN = 3'd3,
    VFPU_MAX = 3'd4,
    VFPU_AND = 3'd5,
    VFPU_OR  = 3'd6,
    VFPU_XOR = 3'd7
  } vfpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } vfpu_state_t;

endpackage

// File: rtl/vfpu_lane_alu.sv
// One combinational SIMD lane of the engine.
//   op  : lane operation
//   a,b : lane operands
//   res : lane result, truncated to LW bits
//   sat : lane clamped (only with VFPU_ENGINE_SATURATE_EN defined; then
//         ADD/SUB saturate as signed values instead of wrapping)
module vfpu_lane_alu
  import vfpu_package::*;
#(
  parameter int LW = VFPU_LANE_WIDTH
) (
  input  vfpu_op_t      op,
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  output logic [LW-1:0] res
`ifdef VFPU_ENGINE_SATURATE_EN
  ,
  output logic          sat
`endif
);

`ifdef VFPU_ENGINE_SATURATE_EN
  // One extra sign bit: overflow shows up as the top two bits disagreeing.
  logic [LW:0] sum, diff;
  assign sum  = {a[LW-1], a} + {b[LW-1], b};
  assign diff = {a[LW-1], a} - {b[LW-1], b};

  function automatic logic [LW-1:0] clamp(input logic [LW:0] v);
    if (v[LW] ^ v[LW-1]) clamp = v[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
    else                 clamp = v[LW-1:0];
  endfunction
`endif

  always_comb begin
    res = '0;
`ifdef VFPU_ENGINE_SATURATE_EN
    sat = 1'b0;
`endif
    case (op)
`ifdef VFPU_ENGINE_SATURATE_EN
      VFPU_ADD: begin res = clamp(sum);  sat = sum[LW]  ^ sum[LW-1];  end
      VFPU_SUB: begin res = clamp(diff); sat = diff[LW] ^ diff[LW-1]; end
`else
      VFPU_ADD: res = a + b;
      VFPU_SUB: res = a - b;
`endif
      VFPU_MUL: res = a * b;
      VFPU_MIN: res = ($signed(a) < $signed(b)) ? a : b;
      VFPU_MAX: res = ($signed(a) > $signed(b)) ? a : b;
      VFPU_AND: res = a & b;
      VFPU_OR:  res = a | b;
      VFPU_XOR: res = a ^ b;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/vfpu_engine.sv
// Pipelined lane-wise SIMD integer ALU between two operand streams and a
// result stream. A job of len_i beats is launched by start_i; done_o pulses
// once the last result has been handed off.
//   clk_i, rst_i, clear_i : clock, sync reset, sync flush (same effect)
//   start_i/opcode_i/len_i: job launch (sampled in IDLE)
//   busy_o, done_o        : job status
//   a_*, b_*              : operand streams (always consumed together)
//   res_*                 : result stream
//   sat_o                 : sticky clamp flag, only with VFPU_ENGINE_SATURATE_EN
module vfpu_engine
  import vfpu_package::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LANE_WIDTH  = 32,
  parameter int PIPE_STAGES = 2,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [2:0]              opcode_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    a_valid_i,
  input  logic                    b_valid_i,
  output logic                    a_ready_o,
  output logic                    b_ready_o,
  input  logic [DATA_WIDTH-1:0]   a_data_i,
  input  logic [DATA_WIDTH-1:0]   b_data_i,
  input  logic [DATA_WIDTH/8-1:0] a_strb_i,
  input  logic [DATA_WIDTH/8-1:0] b_strb_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [DATA_WIDTH-1:0]   res_data_o,
  output logic [DATA_WIDTH/8-1:0] res_strb_o
`ifdef VFPU_ENGINE_SATURATE_EN
  ,
  output logic                    sat_o
`endif
);

  localparam int NB_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int STRB_W   = DATA_WIDTH / 8;

  vfpu_state_t          state;
  vfpu_op_t             op_q;
  logic [LEN_WIDTH-1:0] in_cnt, out_cnt;
  logic                 busy_q, done_q;
  logic                 flush, acc, res_hs;

  logic [PIPE_STAGES-1:0]                 vld_pipe, ld, in_vld;
  logic [PIPE_STAGES-1:0][DATA_WIDTH-1:0] data_pipe, in_data;
  logic [PIPE_STAGES-1:0][STRB_W-1:0]     strb_pipe, in_strb;

  logic [NB_LANES-1:0][LANE_WIDTH-1:0] a_lanes, b_lanes, lane_res;

  assign flush   = rst_i | clear_i;
  assign a_lanes = a_data_i;
  assign b_lanes = b_data_i;

  // ---------------- lanes ----------------
`ifdef VFPU_ENGINE_SATURATE_EN
  logic [NB_LANES-1:0] lane_sat;
  logic                sat_q;
`endif

  for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
    vfpu_lane_alu #(.LW(LANE_WIDTH)) u_lane (
      .op  (op_q),
      .a   (a_lanes[l]),
      .b   (b_lanes[l]),
      .res (lane_res[l])
`ifdef VFPU_ENGINE_SATURATE_EN
      ,
      .sat (lane_sat[l])
`endif
    );
  end

  // ---------------- pipeline control ----------------
  // A stage loads when empty or when its successor advances; the chain
  // ends at the sink ready, so a full pipe streams 1 beat/cycle.
  always_comb begin
    ld = '0;
    ld[PIPE_STAGES-1] = ~vld_pipe[PIPE_STAGES-1] | res_ready_i;
    for (int k = PIPE_STAGES-2; k >= 0; k--) ld[k] = ~vld_pipe[k] | ld[k+1];
  end

  assign acc    = (state == ST_RUN) && (in_cnt != '0) && a_valid_i && b_valid_i && ld[0];
  assign res_hs = vld_pipe[PIPE_STAGES-1] & res_ready_i;

  always_comb begin
    in_vld  = '0;
    in_data = '0;
    in_strb = '0;
    in_vld[0]  = acc;
    in_data[0] = lane_res;
    in_strb[0] = a_strb_i & b_strb_i;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      in_vld[k]  = vld_pipe[k-1];
      in_data[k] = data_pipe[k-1];
      in_strb[k] = strb_pipe[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
      strb_pipe <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (ld[k]) begin
          vld_pipe[k] <= in_vld[k];
          // Bubbles leave the payload untouched.
          if (in_vld[k]) begin
            data_pipe[k] <= in_data[k];
            strb_pipe[k] <= in_strb[k];
          end
        end
      end
    end
  end

  // ---------------- job controller ----------------
  always_ff @(posedge clk_i) begin
    if (flush) begin
      state   <= ST_IDLE;
      op_q    <= VFPU_ADD;
      in_cnt  <= '0;
      out_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (acc)    in_cnt  <= in_cnt  - LEN_WIDTH'(1);
      if (res_hs) out_cnt <= out_cnt - LEN_WIDTH'(1);
      case (state)
        ST_IDLE: if (start_i) begin
          op_q    <= vfpu_op_t'(opcode_i);
          in_cnt  <= len_i;
          out_cnt <= len_i;
          busy_q  <= 1'b1;
          if (len_i == '0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: if (res_hs && out_cnt == LEN_WIDTH'(1)) begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef VFPU_ENGINE_SATURATE_EN
  always_ff @(posedge clk_i) begin
    if (flush)                             sat_q <= 1'b0;
    else if (state == ST_IDLE && start_i)  sat_q <= 1'b0;
    else if (acc && (|lane_sat))           sat_q <= 1'b1;
  end
  assign sat_o = sat_q;
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign a_ready_o   = acc;
  assign b_ready_o   = acc;
  assign res_valid_o = vld_pipe[PIPE_STAGES-1];
  assign res_data_o  = data_pipe[PIPE_STAGES-1];
  assign res_strb_o  = strb_pipe[PIPE_STAGES-1];

endmodule

// File: tb/tb_vfpu_engine.sv
// Scoreboard bench for vfpu_engine (64-bit data, two 32-bit lanes).
module tb_vfpu_engine;
  import vfpu_package::*;

  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, clear_i = 1'b0, start_i = 1'b0;
  logic [2:0]    opcode_i = '0;
  logic [15:0]   len_i = '0;
  logic          busy_o, done_o;
  logic          a_valid_i = 1'b0, b_valid_i = 1'b0, a_ready_o, b_ready_o;
  logic [DW-1:0] a_data_i = '0, b_data_i = '0;
  logic [SW-1:0] a_strb_i = '0, b_strb_i = '0;
  logic          res_valid_o, res_ready_i = 1'b1;
  logic [DW-1:0] res_data_o;
  logic [SW-1:0] res_strb_o;
`ifdef VFPU_ENGINE_SATURATE_EN
  logic          sat_o;
`endif

  vfpu_engine #(.DATA_WIDTH(DW), .LANE_WIDTH(32), .PIPE_STAGES(2), .LEN_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .opcode_i(opcode_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .a_valid_i(a_valid_i), .b_valid_i(b_valid_i), .a_ready_o(a_ready_o), .b_ready_o(b_ready_o),
    .a_data_i(a_data_i), .b_data_i(b_data_i), .a_strb_i(a_strb_i), .b_strb_i(b_strb_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_strb_o(res_strb_o)
`ifdef VFPU_ENGINE_SATURATE_EN
    , .sat_o(sat_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_done = 0;
  int acc_cyc = -1, res_cyc = -1;
  bit lat_arm = 1'b0, ready_toggle = 1'b0;
  logic ready_val = 1'b1;
  logic [SW+DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [SW+DW-1:0] act, input logic [SW+DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Sink ready driver.
  initial forever begin
    @(posedge clk); #1;
    if (ready_toggle) res_ready_i = ~res_ready_i;
    else              res_ready_i = ready_val;
  end

  // Monitor: compares every presented result against the scoreboard head,
  // including while stalled, and pops on handshake.
  initial forever begin
    @(negedge clk);
    if (done_o) done_cnt++;
    chk("ready_pair", {71'd0, a_ready_o}, {71'd0, b_ready_o});
    if (a_ready_o && !(a_valid_i && b_valid_i)) begin
      checks++; errors++;
      $display("FAIL ready_without_valid: a_valid %0b b_valid %0b", a_valid_i, b_valid_i);
    end
    if (lat_arm && a_ready_o && acc_cyc < 0) acc_cyc = cyc;
    if (lat_arm && res_valid_o && res_cyc < 0) res_cyc = cyc;
    if (res_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got %0h expected none", res_data_o);
      end else begin
        chk("result", {res_strb_o, res_data_o}, exp_q[0]);
        if (res_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start(input logic [2:0] op, input logic [15:0] len);
    start_i = 1'b1; opcode_i = op; len_i = len;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [SW-1:0] sa, input logic [SW-1:0] sb,
                      input logic [DW-1:0] exp, input bit randb);
    bit got = 1'b0;
    exp_q.push_back({sa & sb, exp});
    a_data_i = a; b_data_i = b; a_strb_i = sa; b_strb_i = sb;
    a_valid_i = 1'b1;
    b_valid_i = randb ? ($urandom_range(0, 2) != 0) : 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (a_ready_o) got = 1'b1;
      @(posedge clk); #1;
      if (!got && randb) b_valid_i = ($urandom_range(0, 2) != 0);
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no ready expected ready");
    end
  endtask

  task automatic wait_done(input string name);
    exp_done++;
    for (int i = 0; i < 200 && done_cnt < exp_done; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(name, 72'(done_cnt), 72'(exp_done));
    chk({name, "_drained"}, 72'(exp_q.size()), 72'd0);
    chk({name, "_idle"}, {71'd0, busy_o}, 72'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {64'd0, busy_o, done_o, a_ready_o, b_ready_o, res_valid_o, 3'd0},
        72'd0);
    chk("reset_data", {res_strb_o, res_data_o}, 72'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // ADD, 4 beats, full throughput, latency 2.
    lat_arm = 1'b1;
    start(3'd0, 16'd4);
    send(64'h00000100_00000001, 64'h00000200_0000000A, 8'hFF, 8'hFF, 64'h00000300_0000000B, 0);
    send(64'h00000100_00000002, 64'h00000200_00000014, 8'h0F, 8'h3C, 64'h00000300_00000016, 0);
    send(64'h00000100_00000003, 64'h00000200_0000001E, 8'hFF, 8'hFF, 64'h00000300_00000021, 0);
    send(64'h00000100_FFFFFFFF, 64'h00000200_00000001, 8'hFF, 8'hFF, 64'h00000300_00000000, 0);
    wait_done("add_done");
    lat_arm = 1'b0;
    chk("add_latency", 72'(res_cyc - acc_cyc), 72'd2);

    // SUB / MIN / MAX / MUL and bitwise ops, one beat each.
    start(3'd1, 16'd1);
    send(64'h00000005_FFFFFFFE, 64'h00000007_00000003, 8'hFF, 8'hFF, 64'hFFFFFFFE_FFFFFFFB, 0);
    wait_done("sub_done");
    start(3'd3, 16'd1);
    send(64'h00000005_FFFFFFFE, 64'h00000007_00000003, 8'hFF, 8'hFF, 64'h00000005_FFFFFFFE, 0);
    wait_done("min_done");
    start(3'd4, 16'd1);
    send(64'h00000005_FFFFFFFE, 64'h00000007_00000003, 8'hFF, 8'hFF, 64'h00000007_00000003, 0);
    wait_done("max_done");
    start(3'd2, 16'd1);
    send(64'h00000005_FFFFFFFE, 64'h00000007_00000003, 8'hFF, 8'hFF, 64'h00000023_FFFFFFFA, 0);
    wait_done("mul_done");
    start(3'd5, 16'd1);
    send(64'hF0F0F0F0_0000FFFF, 64'h0FF00F0F_00FF00FF, 8'hF0, 8'hFF, 64'h00F00000_000000FF, 0);
    wait_done("and_done");
    start(3'd6, 16'd1);
    send(64'hF0F0F0F0_0000FFFF, 64'h0FF00F0F_00FF00FF, 8'hFF, 8'hFF, 64'hFFF0FFFF_00FFFFFF, 0);
    wait_done("or_done");
    start(3'd7, 16'd1);
    send(64'hF0F0F0F0_0000FFFF, 64'h0FF00F0F_00FF00FF, 8'hFF, 8'h81, 64'hFF00FFFF_00FFFF00, 0);
    wait_done("xor_done");

    // Backpressure: toggling sink ready, random b_valid gaps.
    ready_toggle = 1'b1;
    start(3'd0, 16'd8);
    for (int i = 0; i < 8; i++)
      send({32'(i) << 16, 32'(i)}, {32'd1, 32'(100 * i)}, 8'hFF, 8'hFF,
           {(32'(i) << 16) + 32'd1, 32'(101 * i)}, 1);
    wait_done("bp_done");
    ready_toggle = 1'b0; ready_val = 1'b1;
    @(posedge clk); #1;

    // len 0: no operand ready, done the cycle after start.
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    start(3'd0, 16'd0);
    chk("len0_status", {69'd0, done_o, busy_o, a_ready_o}, {69'd0, 3'b110});
    @(posedge clk); #1;
    chk("len0_after", {70'd0, done_o, busy_o}, 72'd0);
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    exp_done++;
    repeat (2) @(negedge clk);
    chk("len0_done_cnt", 72'(done_cnt), 72'(exp_done));
    @(posedge clk); #1;

    // Second start while busy is ignored.
    start(3'd0, 16'd2);
    start(3'd1, 16'd5);
    send(64'd3,  64'd4,  8'hFF, 8'hFF, 64'd7,  0);
    send(64'd10, 64'd20, 8'hFF, 8'hFF, 64'd30, 0);
    wait_done("restart_ignored");

    // Mid-job clear after 3 of 6 beats.
    start(3'd0, 16'd6);
    send(64'd1, 64'd1, 8'hFF, 8'hFF, 64'd2, 0);
    send(64'd2, 64'd2, 8'hFF, 8'hFF, 64'd4, 0);
    send(64'd3, 64'd3, 8'hFF, 8'hFF, 64'd6, 0);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    exp_q.delete();
    chk("clear_outs", {67'd0, busy_o, done_o, a_ready_o, b_ready_o, res_valid_o}, 72'd0);
    chk("clear_data", {res_strb_o, res_data_o}, 72'd0);
    repeat (5) @(negedge clk);
    chk("clear_no_done", 72'(done_cnt), 72'(exp_done));
    @(posedge clk); #1;
    start(3'd0, 16'd1);
    send(64'd5, 64'd6, 8'hFF, 8'hFF, 64'd11, 0);
    wait_done("after_clear");

`ifdef VFPU_ENGINE_SATURATE_EN
    start(3'd0, 16'd1);
    send(64'h00000000_7FFFFFFF, 64'h00000000_00000001, 8'hFF, 8'hFF, 64'h00000000_7FFFFFFF, 0);
    wait_done("sat_add_done");
    chk("sat_set", {71'd0, sat_o}, 72'd1);
    start(3'd0, 16'd1);
    chk("sat_cleared", {71'd0, sat_o}, 72'd0);
    send(64'd1, 64'd1, 8'hFF, 8'hFF, 64'd2, 0);
    wait_done("sat_plain_done");
    chk("sat_stays_clear", {71'd0, sat_o}, 72'd0);
    start(3'd1, 16'd1);
    send(64'h00000000_80000000, 64'h00000000_00000001, 8'hFF, 8'hFF, 64'h00000000_80000000, 0);
    wait_done("sat_sub_done");
    chk("sat_sub_set", {71'd0, sat_o}, 72'd1);
`endif

    chk("final_queue", 72'(exp_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
